// File: rtl/sudoku_puzzle_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : sudoku_puzzle_loader_if
// Description : Signal bundle between the Sudoku puzzle loader and everything
//               around it: the request side (Go / PuzzleSel), the puzzle ROM,
//               the solver datapath strobes/flags and the run status.
//               master = loader side, slave = environment side.
// Ports       : Go, PuzzleSel              request and puzzle select
//               RomAddr, RomData           synchronous puzzle ROM
//               SolverReset/Value/Enter/Next/Start, SolverLoad/Disp/Fail
//               Busy, Done, Solved, Failed, TimedOut, CycleCount
// Revision    : 1.0 - initial release
// ============================================================================
interface sudoku_puzzle_loader_if #(
    parameter int PUZZLE_BITS = 2,
    parameter int CNT_W       = 24
);
    logic                   Go;
    logic [PUZZLE_BITS-1:0] PuzzleSel;
    logic [PUZZLE_BITS+6:0] RomAddr;
    logic [3:0]             RomData;
    logic                   SolverReset;
    logic [3:0]             SolverValue;
    logic                   SolverEnter;
    logic                   SolverNext;
    logic                   SolverStart;
    logic                   SolverLoad;
    logic                   SolverDisp;
    logic                   SolverFail;
    logic                   Busy;
    logic                   Done;
    logic                   Solved;
    logic                   Failed;
    logic                   TimedOut;
    logic [CNT_W-1:0]       CycleCount;

    modport master (
        input  Go, PuzzleSel, RomData, SolverLoad, SolverDisp, SolverFail,
        output RomAddr, SolverReset, SolverValue, SolverEnter, SolverNext,
               SolverStart, Busy, Done, Solved, Failed, TimedOut, CycleCount
    );

    modport slave (
        output Go, PuzzleSel, RomData, SolverLoad, SolverDisp, SolverFail,
        input  RomAddr, SolverReset, SolverValue, SolverEnter, SolverNext,
               SolverStart, Busy, Done, Solved, Failed, TimedOut, CycleCount
    );
endinterface
`default_nettype wire

// File: rtl/sudoku_puzzle_loader.sv
`default_nettype none
// ============================================================================
// Module      : sudoku_puzzle_loader
// Description : Sequencer for the Sudoku solver datapath. On Go it resets the
//               solver, waits for its LOAD phase, streams the 81 cells of the
//               selected stored puzzle from a synchronous ROM using the
//               Enter/Next strobes, pulses Start, then counts RUN cycles
//               until the solver reports Disp (solved) or Fail.
// Ports       : Clk    - system clock, rising edge
//               Reset  - synchronous, active-high
//               bus    - sudoku_puzzle_loader_if.master (request, ROM,
//                        solver strobes/flags and status outputs)
// Options     : SUDOKU_TIMEOUT_EN - when defined, a RUN lasting
//               TIMEOUT_CYCLES cycles is aborted through TOUT (solver reset
//               pulse) and reported as Failed + TimedOut.
// Revision    : 1.0 - initial release
// ============================================================================
module sudoku_puzzle_loader #(
    parameter int               PUZZLE_BITS    = 2,
    parameter int               CNT_W          = 24,
    parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 24'hFFFFF0
) (
    input  logic                   Clk,
    input  logic                   Reset,
    sudoku_puzzle_loader_if.master bus
);

`ifdef SUDOKU_TIMEOUT_EN
    localparam bit TIMEOUT_ENABLE = 1'b1;
`else
    localparam bit TIMEOUT_ENABLE = 1'b0;
`endif

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_SRST      = 4'd1;
    localparam logic [3:0] S_WAIT_LOAD = 4'd2;
    localparam logic [3:0] S_FETCH     = 4'd3;
    localparam logic [3:0] S_WRITE     = 4'd4;
    localparam logic [3:0] S_KICK      = 4'd5;
    localparam logic [3:0] S_RUN       = 4'd6;
    localparam logic [3:0] S_TOUT      = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;

    localparam logic [6:0]       LAST_CELL    = 7'd80;
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 1'b1;

    logic [3:0]             state;
    logic [3:0]             state_next;
    logic [6:0]             idx;
    logic [PUZZLE_BITS-1:0] sel;
    logic [CNT_W-1:0]       cycle_count;
    logic                   solved;
    logic                   failed;
    logic                   timed_out;

    logic go_accept;
    logic last_cell;
    logic timeout_hit;

    assign go_accept = bus.Go && ((state == S_IDLE) || (state == S_DONE));
    assign last_cell = (idx == LAST_CELL);
    // The count reaches TIMEOUT_CYCLES on the same edge that leaves RUN, so
    // the frozen value reported in DONE is exactly the limit.
    assign timeout_hit = TIMEOUT_ENABLE && (state == S_RUN) &&
                         (cycle_count == TIMEOUT_LAST) &&
                         !bus.SolverDisp && !bus.SolverFail;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.Go) begin
                    state_next = S_SRST;
                end
            end
            S_SRST: begin
                state_next = S_WAIT_LOAD;
            end
            S_WAIT_LOAD: begin
                if (bus.SolverLoad) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_WRITE;
            end
            S_WRITE: begin
                state_next = last_cell ? S_KICK : S_FETCH;
            end
            S_KICK: begin
                state_next = S_RUN;
            end
            S_RUN: begin
                // Disp is checked first so a simultaneous Fail loses.
                if (bus.SolverDisp || bus.SolverFail) begin
                    state_next = S_DONE;
                end else if (timeout_hit) begin
                    state_next = S_TOUT;
                end
            end
            S_TOUT: begin
                state_next = S_DONE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Run registers: puzzle select, cell index, cycle count, result flags
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sel         <= '0;
            idx         <= '0;
            cycle_count <= '0;
            solved      <= 1'b0;
            failed      <= 1'b0;
            timed_out   <= 1'b0;
        end else if (go_accept) begin
            sel         <= bus.PuzzleSel;
            idx         <= '0;
            cycle_count <= '0;
            solved      <= 1'b0;
            failed      <= 1'b0;
            timed_out   <= 1'b0;
        end else begin
            if ((state == S_WRITE) && !last_cell) begin
                idx <= idx + 7'd1;
            end
            if (state == S_RUN) begin
                if (cycle_count != CNT_MAX) begin
                    cycle_count <= cycle_count + 1'b1;
                end
                if (bus.SolverDisp) begin
                    solved <= 1'b1;
                end else if (bus.SolverFail) begin
                    failed <= 1'b1;
                end
            end
            if (state == S_TOUT) begin
                failed    <= 1'b1;
                timed_out <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode (Moore on state and run registers)
    // ------------------------------------------------------------------
    always_comb begin
        bus.RomAddr     = '0;
        bus.SolverReset = 1'b0;
        bus.SolverValue = 4'd0;
        bus.SolverEnter = 1'b0;
        bus.SolverNext  = 1'b0;
        bus.SolverStart = 1'b0;
        bus.Busy        = (state != S_IDLE) && (state != S_DONE);
        bus.Done        = (state == S_DONE);
        bus.Solved      = solved;
        bus.Failed      = failed;
        bus.TimedOut    = timed_out;
        bus.CycleCount  = cycle_count;
        case (state)
            S_SRST, S_TOUT: begin
                bus.SolverReset = 1'b1;
            end
            S_FETCH: begin
                bus.RomAddr = {sel, idx};
            end
            S_WRITE: begin
                // ROM data answers the FETCH address of the previous cycle.
                // Codes above 9 are not legal cell values; load them blank.
                bus.SolverValue = (bus.RomData <= 4'd9) ? bus.RomData : 4'd0;
                bus.SolverEnter = 1'b1;
                // The final cell is written without advancing the cursor.
                bus.SolverNext  = !last_cell;
            end
            S_KICK: begin
                bus.SolverStart = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/sudoku_puzzle_loader.md
Name: sudoku_puzzle_loader

Overview:
- Controller that sequences the Sudoku solver datapath. On a Go request it resets the solver and streams one of 2^PUZZLE_BITS stored 81-cell puzzles from a synchronous ROM into the solver's LOAD phase using its Enter/Next strobes.
- It then pulses Start, times the solve in clock cycles, and reports solved or failed.
- It replaces the manual button-driven loading path for self-test and demo.

Parameters:
- PUZZLE_BITS, 2, width of puzzle select; ROM holds 2^PUZZLE_BITS puzzles.
- CNT_W, 24, width of solve-cycle counter.
- TIMEOUT_CYCLES, 24'hFFFFF0, solve-cycle limit (used only with SUDOKU_TIMEOUT_EN).

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Go  in  1  single-cycle request to load and solve the selected puzzle.
- PuzzleSel  in  PUZZLE_BITS  puzzle index, sampled when Go is accepted.
- RomAddr  out  PUZZLE_BITS+7  {latched PuzzleSel, cell index 0..80}; cells are row-major.
- RomData  in  4  cell value 0..9 (0 = blank); valid one cycle after RomAddr.
- SolverReset  out  1  one-cycle reset pulse to the solver.
- SolverValue  out  4  value presented to solver InputValue.
- SolverEnter  out  1  solver Enter strobe.
- SolverNext  out  1  solver Next strobe.
- SolverStart  out  1  solver Start strobe.
- SolverLoad  in  1  solver Load state flag.
- SolverDisp  in  1  solver Disp state flag (solved).
- SolverFail  in  1  solver Fail state flag (no solution).
- Busy  out  1  high in every state except IDLE and DONE.
- Done  out  1  high in DONE.
- Solved  out  1  last run ended in Disp; valid while Done.
- Failed  out  1  last run ended in Fail or timeout; valid while Done.
- TimedOut  out  1  last run aborted by timeout (tied 0 without the macro).
- CycleCount  out  CNT_W  cycles spent in RUN for the last or current run.

Behaviour:
- Reset (synchronous): state IDLE, cell index 0, selected puzzle 0. All outputs 0: RomAddr, strobes, SolverValue, Busy, Done, Solved, Failed, TimedOut, CycleCount. Reset mid-load or mid-run aborts to IDLE with no further strobes.
- Solver-facing strobes, SolverValue and status outputs are Moore decodes of state and registers.
- IDLE or DONE with Go=1:
  - Latch PuzzleSel.
  - Clear cell index, CycleCount, Solved, Failed and TimedOut.
  - Go to SRST.
  - Go in any other state is ignored.
- SRST: SolverReset=1 for exactly one cycle, then go to WAIT_LOAD.
- WAIT_LOAD: wait until SolverLoad=1, then go to FETCH. There is no timeout here.
- FETCH: RomAddr={sel, idx}, then go to WRITE.
- WRITE:
  - SolverValue = RomData when RomData<=9, else 0.
  - SolverEnter=1.
  - SolverNext=1 only when idx!=80. Enter and Next coincide: the value is written at the current cell and the cursor advances on the same edge.
  - If idx==80, go to KICK; otherwise idx+=1 and go to FETCH.
  - A full load is 2 cycles per cell, so 162 cycles from the first FETCH.
- KICK: SolverStart=1 for one cycle, then go to RUN.
- RUN:
  - CycleCount increments every cycle and saturates at all-ones.
  - SolverDisp=1 → DONE with Solved=1.
  - SolverFail=1 → DONE with Failed=1.
  - If both are asserted, Disp wins.
- DONE: Done=1; CycleCount, Solved and Failed hold until the next accepted Go or Reset.
- SolverValue is 0 and strobes are 0 in every state other than the one named above.

Optional Feature:
- Macro SUDOKU_TIMEOUT_EN.
- With the macro: in RUN, when CycleCount == TIMEOUT_CYCLES-1 and neither Disp nor Fail is seen:
  - Next state is TOUT, where SolverReset=1 for one cycle.
  - Then DONE with Failed=1 and TimedOut=1.
  - CycleCount freezes at TIMEOUT_CYCLES.
- Without the macro: RUN waits indefinitely, CycleCount saturates, and TimedOut is constant 0.

Test Plan:
- Reset then Go with PuzzleSel=1 → SolverReset high exactly 1 cycle. After SolverLoad=1, first RomAddr=9'h080, last RomAddr=9'h0D0. Exactly 81 SolverEnter pulses and 80 SolverNext pulses (none with the last Enter), then one SolverStart.
- ROM cell 5 = 4'hC (out of range) → SolverValue=0 in the WRITE cycle for idx 5. Cell 6 = 7 → SolverValue=7.
- Solver model asserts SolverDisp 1000 cycles after Start → Done=1, Solved=1, Failed=0, CycleCount=1000. The values hold for 50 idle cycles.
- Go pulsed during WRITE at idx 40 → ignored: no extra SolverReset, and the load completes normally.
- Reset asserted in RUN with CycleCount=300 → next cycle state IDLE, all outputs 0. A subsequent Go runs a full fresh sequence.
- With SUDOKU_TIMEOUT_EN, TIMEOUT_CYCLES=64, solver never finishes → one SolverReset pulse at RUN cycle 64. Then Done=1, Failed=1, TimedOut=1, CycleCount=64.
